load_store_unit: RTL and testbench

- Multi-cycle data-memory access stage directly downstream of the CPU datapath's load/store port; replaces the single-cycle combinational data memory.
- Takes the datapath's effective address, store data and funct3, and drives a word-wide valid/ready memory bus.
- Returns aligned, sign- or zero-extended load data to the register write-back mux.
- Holds a stall to the CPU until the access completes.

---
 rtl/load_store_unit.sv | 164 ++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: turns a CPU load/store request into a word-wide
// valid/ready bus access and returns extended load data with a CPU stall.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_e;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        latch_en;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        in_addr;

    function automatic logic req_illegal(input logic wr, input logic [2:0] f3,
                                         input logic [1:0] a);
        logic bad_f3;
        logic misal;
        bad_f3 = wr ? (f3 >= 3'b011)
                    : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        case (f3[1:0])
            2'b01:   misal = a[0];
            2'b10:   misal = (a != 2'b00);
            default: misal = 1'b0;
        endcase
        return bad_f3 | misal;
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        case (f3[1:0])
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            2'b10:   return wd;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [31:0] s;
        s = word >> {a, 3'b000};
        case (f3)
            3'b000:  return {{24{s[7]}}, s[7:0]};
            3'b100:  return {24'h0, s[7:0]};
            3'b001:  return {{16{s[15]}}, s[15:0]};
            3'b101:  return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Request and result holding registers carry data only, so no reset.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
        rdata_q <= rdata_d;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        latch_en = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    latch_en = 1'b1;
                    cnt_d    = '0;
                    rdata_d  = '0;
                    err_d    = req_illegal(req_write, req_funct3, req_addr[1:0]);
                    state_d  = err_d ? DONE : ADDR;
                end
            end
            ADDR: begin
                // Timeout wins over a handshake arriving on the same edge.
                if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (bus_ready) state_d = write_q ? DONE : RESP;
                end
            end
            RESP: begin
                if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    if (bus_rvalid) begin
                        rdata_d = load_extract(funct3_q, addr_q[1:0], bus_rdata);
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_addr   = (state_q == ADDR);
    assign bus_valid = in_addr;
    assign bus_write = in_addr & write_q;
    assign bus_addr  = in_addr ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wstrb = bus_write ? store_strb(funct3_q, addr_q[1:0]) : 4'h0;
    assign bus_wdata = bus_write ? store_data(funct3_q, wdata_q) : 32'h0;

    // Gated by reset so the stall drops the instant reset asserts.
    assign stall     = reset & req_valid & (state_q != DONE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;
    assign rsp_error = rsp_valid & err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed and random accesses compared against a
// byte-arithmetic reference model of the access rules.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        stall, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_write;
    logic        bus_ready = 1'b0, bus_rvalid = 1'b0;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata = 32'h0;

    int compared = 0;
    int mismatched = 0;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_write(bus_write),
        .bus_addr(bus_addr), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: sizes in bytes, lanes by modular arithmetic, extension by masks.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word,
                         input int rdly, input int rvd,
                         output bit ill, output bit err, output logic [31:0] rdata,
                         output logic [3:0] strb, output logic [31:0] wdat,
                         output int cycles);
        int size, o, needed;
        logic [31:0] mask, s, v;
        bit legal;
        size = 1 << f3[1:0];
        o = a % 4;
        if (wr) legal = (f3 <= 2);
        else    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        ill = !legal || ((a % size) != 0);
        strb = 4'h0; wdat = 32'h0; rdata = 32'h0;
        if (legal && wr) begin
            strb = 4'(((1 << size) - 1) << o);
            if (size == 1) wdat = (wd % 256) * 32'h01010101;
            else if (size == 2) wdat = (wd % 65536) * 32'h00010001;
            else wdat = wd;
        end
        needed = (rdly + 1) + (wr ? 0 : rvd);
        if (ill) begin
            err = 1'b1; cycles = 2;
        end else if (needed >= TO) begin
            err = 1'b1; cycles = TO + 2;
        end else begin
            err = 1'b0; cycles = needed + 2;
            if (!wr) begin
                s = word >> (8 * o);
                mask = (size == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * size)) - 1);
                v = s & mask;
                if (f3[2] == 1'b0 && size < 4 && v >= (mask + 1) / 2) v = v | ~mask;
                rdata = v;
            end
        end
    endtask

    // Starts in IDLE just after a falling edge; ends in IDLE just after a falling edge.
    task automatic run(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word,
                       input int rdly, input int rvd, input string tag);
        bit ill, eerr, done, seen, accepted, stable;
        logic [31:0] erd, ewd, ba, bwd, rr;
        logic [3:0] es, bs;
        logic bwr, re;
        int ec, cyc, stalls, vcnt, rcnt;
        model(wr, f3, a, wd, word, rdly, rvd, ill, eerr, erd, es, ewd, ec);
        done = 0; seen = 0; accepted = 0; stable = 1;
        cyc = 0; stalls = 0; vcnt = 0; rcnt = 0;
        ba = 0; bwd = 0; bs = 0; bwr = 0; rr = 0; re = 0;
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        #1;
        while (!done && cyc < 60) begin
            cyc++;
            if (stall) stalls++;
            if (bus_valid) begin
                vcnt++;
                if (!seen) begin
                    seen = 1; ba = bus_addr; bs = bus_wstrb; bwd = bus_wdata; bwr = bus_write;
                end else if (bus_addr !== ba || bus_wstrb !== bs || bus_wdata !== bwd || bus_write !== bwr)
                    stable = 0;
            end
            if (rsp_valid) begin
                rr = rsp_rdata; re = rsp_error; done = 1;
            end
            if (accepted) rcnt++;
            bus_rvalid = accepted && !done && (rcnt == rvd);
            bus_rdata  = bus_rvalid ? word : $urandom;
            bus_ready  = bus_valid && (vcnt > rdly);
            if (bus_valid && bus_ready && !bus_write) accepted = 1;
            if (done) begin
                bus_ready = 1'b0; bus_rvalid = 1'b0; req_valid = 1'b0;
            end else begin
                @(negedge clk); #1;
            end
        end
        check({tag, " done"}, 32'(done), 32'(1));
        check({tag, " error"}, 32'(re), 32'(eerr));
        check({tag, " rdata"}, rr, erd);
        check({tag, " cycles"}, 32'(cyc), 32'(ec));
        check({tag, " stall cycles"}, 32'(stalls), 32'(ec - 1));
        check({tag, " bus used"}, 32'(seen), 32'(!ill));
        if (!ill) begin
            check({tag, " bus_addr"}, ba, a - (a % 4));
            check({tag, " bus_write"}, 32'(bwr), 32'(wr));
            check({tag, " bus_wstrb"}, 32'(bs), 32'(es));
            check({tag, " bus_wdata"}, bwd, ewd);
            check({tag, " bus stable"}, 32'(stable), 32'(1));
        end
        @(negedge clk); #1;
        check({tag, " rsp pulse end"}, 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        bit wr;
        logic [2:0] f3;
        req_valid = 1'b1;
        #2;
        check("reset bus_valid", 32'(bus_valid), 32'(0));
        check("reset stall", 32'(stall), 32'(0));
        check("reset rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset rsp_rdata", rsp_rdata, 32'h0);
        @(negedge clk); #1;
        req_valid = 1'b0; reset = 1'b1;
        @(negedge clk); #1;

        run(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, "sw");
        run(1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF7F01, 0, 1, "lb");
        run(1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF7F01, 0, 1, "lbu");
        run(1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF7F01, 0, 1, "lh");
        run(1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0, 0, 1, "sh");
        run(1'b1, 3'b000, 32'h21, 32'h1234ABCD, 32'h0, 0, 1, "sb");
        run(1'b0, 3'b010, 32'h06, 32'h0, 32'h12345678, 0, 1, "lw misaligned");
        run(1'b1, 3'b001, 32'h01, 32'hFFFF, 32'h0, 0, 1, "sh misaligned");
        run(1'b0, 3'b110, 32'h40, 32'h0, 32'h0, 0, 1, "load f3 110");
        run(1'b1, 3'b011, 32'h40, 32'h0, 32'h0, 0, 1, "store f3 011");
        run(1'b0, 3'b010, 32'h30, 32'h0, 32'h0, 1000, 1, "timeout");

        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("stray rvalid rsp_valid", 32'(rsp_valid), 32'(0));
        end
        bus_rvalid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            run(wr, f3, 32'($urandom_range(0, 1023)), $urandom, $urandom,
                $urandom_range(0, 3), $urandom_range(1, 3), $sformatf("rand%0d", i));
        end

        // Reset while the request is on the bus.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
        bus_ready = 1'b0;
        @(negedge clk); #1;
        check("addr bus_valid", 32'(bus_valid), 32'(1));
        reset = 1'b0; #1;
        check("reset in addr bus_valid", 32'(bus_valid), 32'(0));
        check("reset in addr stall", 32'(stall), 32'(0));
        @(negedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;

        // Reset while waiting for read data.
        req_valid = 1'b1; bus_ready = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        bus_ready = 1'b0;
        check("resp stall", 32'(stall), 32'(1));
        reset = 1'b0; #1;
        check("reset in resp stall", 32'(stall), 32'(0));
        check("reset in resp rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset in resp bus_valid", 32'(bus_valid), 32'(0));
        @(negedge clk); #1;
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk); #1;

        run(1'b0, 3'b010, 32'h0, 32'h0, 32'h5, 0, 1, "lw after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
